// File: rtl/team_06_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : team_06_echo_pkg
// Purpose : Shared types, default sizes and helpers for the echo delay line.
//           Provides the controller state enum, default parameter values and
//           a saturating unsigned adder used by the mixer.
// Revision: 1.0 - initial release
// ============================================================================
package team_06_echo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_GAIN_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MIX   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } echo_state_t;

  // Unsigned a + b clamped to 2**w - 1. Operands are carried in 32 bits with
  // a 33-bit internal sum so the carry is never lost; w must be 1..32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/team_06_echo_mixer.sv
`default_nettype none
// ============================================================================
// Module  : team_06_echo_mixer
// Purpose : Combinational echo mix: sum = sat(dry + ((past * decay) >> GAIN_W)).
// Ports   : i_dry   - dry input sample
//           i_past  - history sample (already zeroed when history not primed)
//           i_decay - gain numerator, already clamped to 2**GAIN_W
//           o_sum   - mixed sample saturated to 2**DATA_W - 1
// Revision: 1.0 - initial release
// ============================================================================
module team_06_echo_mixer
  import team_06_echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAIN_W = DEF_GAIN_W
) (
  input  logic [DATA_W-1:0] i_dry,
  input  logic [DATA_W-1:0] i_past,
  input  logic [GAIN_W:0]   i_decay,
  output logic [DATA_W-1:0] o_sum
);

  localparam int c_PROD_W = DATA_W + GAIN_W + 1;

  logic [c_PROD_W-1:0] w_prod;

  // Both operands widened to the full product width before multiplying.
  assign w_prod = {{(GAIN_W+1){1'b0}}, i_past} * {{DATA_W{1'b0}}, i_decay};

  assign o_sum = DATA_W'(sat_add(32'(w_prod >> GAIN_W), 32'(i_dry), DATA_W));

endmodule
`default_nettype wire

// File: rtl/team_06_echo_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : team_06_echo_delay_line
// Purpose : Echo engine with the feedback history kept in external SRAM.
//           Per sample: read history d back, scale by decay, mix with the dry
//           input (saturating), write the mix back as the newest history.
// Ports   : clk, rst (async, active-high)
//           i_sample_in/i_sample_valid  - dry sample + strobe
//           i_bypass                    - output the dry sample instead of mix
//           i_delay, i_decay            - echo distance and feedback gain
//           o_mem_rd_*/i_mem_rd_*       - SRAM read request/ack channel
//           o_mem_wr_*/i_mem_wr_ack     - SRAM write request/ack channel
//           o_echo_out/o_out_valid      - processed sample + strobe
//           o_busy, o_overrun           - status (overrun is sticky)
// Revision: 1.0 - initial release
// ============================================================================
module team_06_echo_delay_line
  import team_06_echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int GAIN_W = DEF_GAIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_sample_valid,
  input  logic              i_bypass,
  input  logic [ADDR_W-1:0] i_delay,
  input  logic [GAIN_W:0]   i_decay,
  output logic              o_mem_rd_req,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic              i_mem_rd_ack,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_mem_wr_req,
  output logic [ADDR_W-1:0] o_mem_wr_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic              i_mem_wr_ack,
  output logic [DATA_W-1:0] o_echo_out,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [GAIN_W:0]   c_UNITY    = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_FILL_MAX = {ADDR_W{1'b1}};

  echo_state_t       r_state;
  logic [DATA_W-1:0] r_dry;
  logic [DATA_W-1:0] r_past;
  logic [GAIN_W:0]   r_decay;
  logic              r_bypass;
  logic              r_primed;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill;

  logic [ADDR_W-1:0] w_delay_eff;
  logic [GAIN_W:0]   w_decay_clamped;
  logic [DATA_W-1:0] w_mix_sum;

  assign w_delay_eff     = (i_delay == '0) ? c_ONE : i_delay;
  assign w_decay_clamped = (i_decay > c_UNITY) ? c_UNITY : i_decay;

  team_06_echo_mixer #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_mixer (
    .i_dry   (r_dry),
    .i_past  (r_past),
    .i_decay (r_decay),
    .o_sum   (w_mix_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dry         <= '0;
      r_past        <= '0;
      r_decay       <= '0;
      r_bypass      <= 1'b0;
      r_primed      <= 1'b0;
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      o_mem_rd_req  <= 1'b0;
      o_mem_rd_addr <= '0;
      o_mem_wr_req  <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
      o_echo_out    <= '0;
      o_out_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_out_valid <= 1'b0;
      // Any strobe outside IDLE (DONE included) is dropped and flagged.
      if (i_sample_valid && (r_state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_sample_valid) begin
            r_dry         <= i_sample_in;
            r_bypass      <= i_bypass;
            r_decay       <= w_decay_clamped;
            // Priming decided now: history shorter than d reads as silence.
            r_primed      <= (r_fill >= w_delay_eff);
            o_mem_rd_addr <= r_wr_ptr - w_delay_eff;
            o_mem_rd_req  <= 1'b1;
            o_busy        <= 1'b1;
            r_state       <= S_READ;
          end
        end
        S_READ: begin
          if (i_mem_rd_ack) begin
            o_mem_rd_req <= 1'b0;
            r_past       <= r_primed ? i_mem_rd_data : '0;
            r_state      <= S_MIX;
          end
        end
        S_MIX: begin
          o_mem_wr_req  <= 1'b1;
          o_mem_wr_addr <= r_wr_ptr;
          o_mem_wr_data <= w_mix_sum;
          r_state       <= S_WRITE;
        end
        S_WRITE: begin
          if (i_mem_wr_ack) begin
            o_mem_wr_req <= 1'b0;
            r_wr_ptr     <= r_wr_ptr + c_ONE;
            if (r_fill != c_FILL_MAX) begin
              r_fill <= r_fill + c_ONE;
            end
            o_out_valid <= 1'b1;
            // The write data register still holds the mixed sum here.
            o_echo_out  <= r_bypass ? r_dry : o_mem_wr_data;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_team_06_echo_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : tb_team_06_echo_delay_line
// Purpose : Self-checking bench for team_06_echo_delay_line. A behavioural SRAM
//           answers the DUT; a history queue predicts every address, write
//           value, echo output and latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_team_06_echo_delay_line;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 13;
  localparam int GAIN_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] i_sample_in;
  logic              i_sample_valid;
  logic              i_bypass;
  logic [ADDR_W-1:0] i_delay;
  logic [GAIN_W:0]   i_decay;
  logic              o_mem_rd_req;
  logic [ADDR_W-1:0] o_mem_rd_addr;
  logic              i_mem_rd_ack;
  logic [DATA_W-1:0] i_mem_rd_data;
  logic              o_mem_wr_req;
  logic [ADDR_W-1:0] o_mem_wr_addr;
  logic [DATA_W-1:0] o_mem_wr_data;
  logic              i_mem_wr_ack;
  logic [DATA_W-1:0] o_echo_out;
  logic              o_out_valid;
  logic              o_busy;
  logic              o_overrun;

  team_06_echo_delay_line #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .GAIN_W (GAIN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample_in    (i_sample_in),
    .i_sample_valid (i_sample_valid),
    .i_bypass       (i_bypass),
    .i_delay        (i_delay),
    .i_decay        (i_decay),
    .o_mem_rd_req   (o_mem_rd_req),
    .o_mem_rd_addr  (o_mem_rd_addr),
    .i_mem_rd_ack   (i_mem_rd_ack),
    .i_mem_rd_data  (i_mem_rd_data),
    .o_mem_wr_req   (o_mem_wr_req),
    .o_mem_wr_addr  (o_mem_wr_addr),
    .o_mem_wr_data  (o_mem_wr_data),
    .i_mem_wr_ack   (i_mem_wr_ack),
    .o_echo_out     (o_echo_out),
    .o_out_valid    (o_out_valid),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [DATA_W-1:0] sram [DEPTH];
  int                hist[$];     // every value written since reset, oldest first
  int                last_echo;
  int                last_wr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample through the engine. rd_wait/wr_wait are ack delays in cycles;
  // ovr injects a second strobe during the first READ cycle.
  task automatic run_sample(input int din, input int dly, input int dec,
                            input bit byp, input int rd_wait, input int wr_wait,
                            input bit ovr);
    int n, d, g, past, wet, sum, echo, cyc, rd_cnt, wr_cnt;
    bit done;
    n    = hist.size();
    d    = (dly == 0) ? 1 : dly;
    g    = (dec > 16) ? 16 : dec;
    past = (n >= d) ? hist[n-d] : 0;
    wet  = (past * g) / 16;
    sum  = (din + wet > 255) ? 255 : din + wet;
    echo = byp ? din : sum;

    @(negedge clk);
    chk("echo_hold", int'(o_echo_out), last_echo);
    i_sample_in = DATA_W'(din); i_delay = ADDR_W'(dly); i_decay = (GAIN_W+1)'(dec);
    i_bypass = byp; i_sample_valid = 1'b1;
    cyc = 0; rd_cnt = 0; wr_cnt = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      i_sample_valid = (ovr && cyc == 1);
      if (ovr && cyc == 1) i_sample_in = DATA_W'(din ^ 8'h5A);
      i_mem_rd_ack = 1'b0;
      i_mem_wr_ack = 1'b0;
      if (cyc == 1) chk("busy", int'(o_busy), 1);
      if (o_mem_rd_req && o_mem_wr_req) chk("req_overlap", 1, 0);
      if (o_mem_rd_req) begin
        chk("rd_addr", int'(o_mem_rd_addr), (n - d + DEPTH) % DEPTH);
        if (rd_cnt == rd_wait) begin
          i_mem_rd_ack  = 1'b1;
          i_mem_rd_data = sram[o_mem_rd_addr];
        end
        rd_cnt++;
      end
      if (o_mem_wr_req) begin
        chk("wr_addr", int'(o_mem_wr_addr), n % DEPTH);
        chk("wr_data", int'(o_mem_wr_data), sum);
        if (wr_cnt == wr_wait) begin
          i_mem_wr_ack = 1'b1;
          sram[o_mem_wr_addr] = o_mem_wr_data;
        end
        wr_cnt++;
      end
      if (o_out_valid) done = 1'b1;
      if (cyc > 40) begin
        chk("timeout", 1, 0);
        done = 1'b1;
      end
    end
    i_mem_rd_ack = 1'b0;
    i_mem_wr_ack = 1'b0;
    chk("echo", int'(o_echo_out), echo);
    chk("latency", cyc, 4 + rd_wait + wr_wait);
    chk("rd_cycles", rd_cnt, rd_wait + 1);
    chk("wr_cycles", wr_cnt, wr_wait + 1);
    if (ovr) chk("overrun", int'(o_overrun), 1);
    hist.push_back(sum);
    last_echo = echo;
    last_wr   = sum;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_req"},  int'(o_mem_rd_req), 0);
    chk({tag, "_wr_req"},  int'(o_mem_wr_req), 0);
    chk({tag, "_outs"},    int'({o_mem_rd_addr, o_mem_wr_addr, o_mem_wr_data,
                                 o_echo_out, o_out_valid, o_busy, o_overrun}), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    rst = 1'b1; i_sample_in = '0; i_sample_valid = 1'b0; i_bypass = 1'b0;
    i_delay = '0; i_decay = '0; i_mem_rd_ack = 1'b0; i_mem_rd_data = '0;
    i_mem_wr_ack = 1'b0;
    last_echo = 0; last_wr = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Priming: first two outputs see silent history, third sees 10.
    run_sample(10, 2, 16, 0, 0, 0, 0);
    run_sample(20, 2, 16, 0, 0, 0, 0);
    run_sample(30, 2, 16, 0, 0, 0, 0);
    chk("prime_third", last_echo, 40);

    // Saturation: 200 in history, 100 dry at unity gain.
    run_sample(200, 1, 0, 0, 0, 0, 0);
    run_sample(100, 1, 16, 0, 0, 0, 0);
    chk("sat_echo", last_echo, 255);
    chk("sat_wr", last_wr, 255);

    // Decay scaling, then over-range decay clamped to unity.
    run_sample(64, 1, 0, 0, 0, 0, 0);
    run_sample(0, 1, 4, 0, 0, 0, 0);
    chk("decay_quarter", last_echo, 16);
    run_sample(0, 2, 31, 0, 0, 0, 0);
    chk("decay_clamp", last_echo, 64);

    // Handshake stalls (latency checked inside the task as 9).
    run_sample(55, 3, 8, 0, 3, 2, 0);
    run_sample(7, 0, 16, 0, 1, 1, 0);

    // Overrun: second strobe during READ is dropped and sticky flag sets.
    run_sample(33, 1, 8, 0, 0, 0, 1);
    run_sample(44, 1, 8, 0, 2, 0, 0);
    chk("overrun_sticky", int'(o_overrun), 1);

    // Bypass: output is dry, write still carries the mix.
    run_sample(77, 1, 16, 1, 0, 0, 0);
    chk("bypass_echo", last_echo, 77);

    // Randomised traffic.
    for (int k = 0; k < 60; k++) begin
      run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    // Reset while WRITE is pending.
    @(negedge clk);
    i_sample_in = 8'd99; i_delay = 13'd1; i_decay = 5'd16; i_sample_valid = 1'b1;
    @(negedge clk);
    i_sample_valid = 1'b0;
    i_mem_rd_ack = 1'b1; i_mem_rd_data = 8'd0;
    begin
      int guard;
      guard = 0;
      while (!o_mem_wr_req && guard < 20) begin
        @(negedge clk);
        i_mem_rd_ack = 1'b0;
        guard++;
      end
      chk("reach_write", int'(o_mem_wr_req), 1);
    end
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    i_mem_rd_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    last_echo = 0;

    // Long run at delay 1 so the pointer wraps through address 0.
    for (int k = 0; k < DEPTH + 20; k++) begin
      run_sample(int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 16)),
                 0, 0, 0, 0);
    end
    chk("overrun_clear", int'(o_overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
